// File: rtl/mdu_pkg.sv
// mdu_pkg: shared types, constants and op-decoding helpers for the iterative multiply/divide unit
package mdu_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] DIV_ZERO_Q = '1;
  typedef enum logic [2:0] {
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU
  } mdu_op_e;
  typedef enum logic [1:0] {IDLE, CALC, DONE} mdu_state_e;
  function automatic logic is_div(mdu_op_e op);
    return op[2];
  endfunction
  function automatic logic is_signed_a(mdu_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction
  function automatic logic is_signed_b(mdu_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction
endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide; define MDU_FAST_PATH_EN to finish trivial ops in one cycle
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [2:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_a,
  input  logic [DATA_WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_result,
  output logic                  busy
);
  localparam int W = DATA_WIDTH;
  localparam int CW = $clog2(W) + 1;
  mdu_state_e state, state_nxt;
  mdu_op_e op_q, op_in;
  logic [2*W-1:0] acc, acc_nxt, prod;
  logic [W-1:0] bmag, res_q, res_nxt, mag_a, mag_b, quo, rem, fast_res;
  logic [W:0] mul_sum, div_t, div_diff;
  logic [CW-1:0] cnt;
  logic neg, neg_in, sa, sb, accept, last, fast, div_ge;
  assign op_in = mdu_op_e'(req_op);
  assign sa = is_signed_a(op_in) & req_a[W-1];
  assign sb = is_signed_b(op_in) & req_b[W-1];
  assign mag_a = sa ? -req_a : req_a;
  assign mag_b = sb ? -req_b : req_b;
  // a zero divisor must leave the all-ones quotient un-negated; remainder sign follows the dividend
  assign neg_in = is_div(op_in) ? (op_in[1] ? sa : (sa ^ sb) & (|req_b)) : sa ^ sb;
  assign accept = req_valid & req_ready & !flush;
  assign last = cnt == CW'(W - 1);
`ifdef MDU_FAST_PATH_EN
  logic dz, ovf;
  assign dz = is_div(op_in) & ~|req_b;
  assign ovf = is_div(op_in) & is_signed_a(op_in) & (req_a == {1'b1, {(W-1){1'b0}}}) & (&req_b);
  assign fast = dz | ovf | (!is_div(op_in) & (~|req_a | ~|req_b));
  assign fast_res = dz ? (op_in[1] ? req_a : W'(DIV_ZERO_Q)) : (ovf & !op_in[1]) ? req_a : '0;
`else
  assign fast = 1'b0;
  assign fast_res = '0;
`endif
  // acc holds the product for multiplies and {remainder, quotient} for divides
  always_comb begin
    mul_sum = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, bmag} : '0);
    div_t = acc[2*W-1:W-1];
    div_diff = div_t - {1'b0, bmag};
    div_ge = div_t >= {1'b0, bmag};
    acc_nxt = is_div(op_q) ? (div_ge ? {div_diff[W-1:0], acc[W-2:0], 1'b1}
                                     : {div_t[W-1:0], acc[W-2:0], 1'b0})
                           : {mul_sum, acc[W-1:1]};
    prod = neg ? -acc_nxt : acc_nxt;
    quo = neg ? -acc_nxt[W-1:0] : acc_nxt[W-1:0];
    rem = neg ? -acc_nxt[2*W-1:W] : acc_nxt[2*W-1:W];
    res_nxt = !is_div(op_q) ? (op_q == OP_MUL ? prod[W-1:0] : prod[2*W-1:W]) : op_q[1] ? rem : quo;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      bmag <= '0;
      op_q <= OP_MUL;
      neg <= 1'b0;
      cnt <= '0;
      res_q <= '0;
    end else if (accept) begin
      acc <= {{W{1'b0}}, mag_a};
      bmag <= mag_b;
      op_q <= op_in;
      neg <= neg_in;
      cnt <= '0;
      if (fast) res_q <= fast_res;
    end else if (state == CALC && !flush) begin
      acc <= acc_nxt;
      cnt <= cnt + CW'(1);
      if (last) res_q <= res_nxt;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = flush ? IDLE
              : state == IDLE ? (accept ? (fast ? DONE : CALC) : IDLE)
              : state == CALC ? (last ? DONE : CALC)
              : (rsp_ready ? IDLE : DONE);
  end
  always_comb begin
    req_ready = state == IDLE;
    rsp_valid = state == DONE;
    busy = state != IDLE;
  end
  assign rsp_result = res_q;
endmodule
